// File: rtl/dmem_pkg.sv
// Shared size codes, FSM encodings and the access-legality check for the
// data-memory arbiter.
package dmem_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  typedef struct packed {
    logic       id;
    logic       we;
    logic [1:0] size;
    logic       uns;
  } req_ctl_t;

  // Alignment is judged on the low address bits; range is resolved by the caller.
  function automatic logic access_err(input logic [1:0] lo, input logic [1:0] size,
                                      input logic out_of_range);
    logic bad;
    bad = out_of_range;
    case (size)
      SZ_H:    bad = bad | lo[0];
      SZ_W:    bad = bad | (lo != 2'b00);
      SZ_RSV:  bad = 1'b1;
      default: bad = bad;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/halfword lane handling: load extract with sign/zero extension and
// store merge of a sub-word into a full memory word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lo_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{lo_i, 3'b000} +: 8];
  assign half_sel = word_i[{lo_i[1], 4'b0000} +: 16];

  always_comb begin
    case (size_i)
      SZ_B:    rdata_o = uns_i ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    rdata_o = uns_i ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: rdata_o = word_i;
    endcase
  end

  always_comb begin
    merged_o = word_i;
    case (size_i)
      SZ_B:    merged_o[{lo_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_H:    merged_o[{lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the word-wide data
// memory; sub-word stores are done as read-modify-write.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = 2048,
  parameter int ADDR_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [3:0]          req_size,
  input  logic [1:0]          req_uns,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [63:0]         req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wd,
  output logic                mem_we,
  input  logic [31:0]         mem_rd
);

  logic [1:0]        state_q, state_d;
  logic              rr_last_q, rr_last_d;
  req_ctl_t          ctl_q, ctl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [1:0]        size_arr  [2];
  logic [ADDR_W-1:0] addr_arr  [2];
  logic [31:0]       wdata_arr [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign size_arr[gi]  = req_size[2*gi +: 2];
      assign addr_arr[gi]  = req_addr[ADDR_W*gi +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[32*gi +: 32];
    end
  endgenerate

  // Grant exists only in IDLE; on contention the port that did not win last goes.
  logic [1:0] grant;
  logic       gsel;
  logic       xfer;

  always_comb begin
    grant = 2'b00;
    if (state_q == S_IDLE) begin
      if (req_valid == 2'b11) grant = rr_last_q ? 2'b01 : 2'b10;
      else                    grant = req_valid;
    end
  end

  assign gsel      = grant[1];
  assign xfer      = rst_n && (grant != 2'b00);
  assign req_ready = rst_n ? grant : 2'b00;

  logic [ADDR_W-1:0] mem_base;
  logic              out_of_range;
  logic              acc_err;
  logic [31:0]       align_word;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  assign mem_base     = {addr_q[ADDR_W-1:2], 2'b00};
  assign out_of_range = mem_base > ADDR_W'(MEM_BYTES - 4);
  assign acc_err      = access_err(addr_q[1:0], ctl_q.size, out_of_range);
  assign align_word   = (state_q == S_WRITE) ? word_q : mem_rd;

  dmem_lane_align u_align (
    .word_i   (align_word),
    .wdata_i  (wdata_q),
    .lo_i     (addr_q[1:0]),
    .size_i   (ctl_q.size),
    .uns_i    (ctl_q.uns),
    .rdata_o  (load_data),
    .merged_o (merged)
  );

  logic              mem_we_c;
  logic [31:0]       mem_wd_c;
  logic [ADDR_W-1:0] mem_addr_c;

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    ctl_d      = ctl_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_we_c   = 1'b0;
    mem_wd_c   = 32'd0;
    mem_addr_c = '0;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          ctl_d.id   = gsel;
          ctl_d.we   = req_we[gsel];
          ctl_d.size = size_arr[gsel];
          ctl_d.uns  = req_uns[gsel];
          addr_d     = addr_arr[gsel];
          wdata_d    = wdata_arr[gsel];
          rdata_d    = 32'd0;
          err_d      = 1'b0;
          rr_last_d  = gsel;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_addr_c = mem_base;
        if (acc_err) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (!ctl_q.we) begin
          rdata_d = load_data;
          state_d = S_RESP;
        end else if (ctl_q.size == SZ_W) begin
          mem_we_c = 1'b1;
          mem_wd_c = wdata_q;
          state_d  = S_RESP;
        end else begin
          word_d  = mem_rd;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_addr_c = mem_base;
        mem_we_c   = 1'b1;
        mem_wd_c   = merged;
        state_d    = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gating by rst_n keeps a reset landing mid-transaction from writing memory.
  assign mem_we   = rst_n & mem_we_c;
  assign mem_wd   = rst_n ? mem_wd_c : 32'd0;
  assign mem_addr = rst_n ? mem_addr_c : '0;

  logic rsp_active;
  assign rsp_active = rst_n && (state_q == S_RESP);
  assign rsp_valid  = rsp_active ? (ctl_q.id ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata  = rsp_active ? rdata_q : 32'd0;
  assign rsp_err    = rsp_active & err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_last_q <= 1'b1;
      ctl_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      word_q    <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      ctl_q     <= ctl_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      word_q    <= word_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a byte-level
// transaction model of memory, arbitration and response timing.
module tb_dmem_arbiter;

  localparam int MEM_BYTES = 2048;
  localparam int AW        = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_we, req_uns, rsp_valid;
  logic [3:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] rsp_rdata, mem_wd, mem_rd, mem_addr;
  logic        rsp_err, mem_we;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_we(mem_we), .mem_rd(mem_rd)
  );

  function automatic logic [31:0] init_word(int i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  // Environment memory: combinational read, whole-word write.
  logic [31:0] mem [512];
  logic        mem_ready = 1'b0;
  assign mem_rd = mem[mem_addr[10:2]];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[10:2]] <= mem_wd;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  shadow [MEM_BYTES];
  bit          shadow_ready = 0;
  int          cyc = 0;
  bit          m_busy = 0;
  int          m_k, m_resp_k, m_wr_k, m_id, m_nb;
  bit          m_rr_last = 1;
  logic [31:0] m_addr, m_wdata, m_rdata, m_wd;
  bit          m_err;
  bit          acc [2];
  int          xfer_cyc [2], rsp_cyc [2], rsp_cnt [2];
  logic [31:0] last_rdata [2];
  logic        last_err [2];
  logic [31:0] last_wd;
  int          we_count = 0;
  int          grant_log [$];

  always @(posedge clk) cyc++;

  function automatic logic [31:0] load_val(logic [31:0] a, int nb, bit uns);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < nb; i++) v |= 32'(shadow[int'(a) + i]) << (8 * i);
    if (!uns && nb < 4 && v[8*nb-1]) v |= ~((32'd1 << (8 * nb)) - 32'd1);
    return v;
  endfunction

  function automatic logic [31:0] merge_val(logic [31:0] a, int nb, logic [31:0] wd);
    logic [31:0] w;
    int base, lane;
    base = int'(a) & ~3;
    w = 32'd0;
    for (int i = 0; i < 4; i++) w |= 32'(shadow[base + i]) << (8 * i);
    for (int i = 0; i < nb; i++) begin
      lane = (int'(a) % 4) + i;
      w[8*lane +: 8] = wd[8*i +: 8];
    end
    return w;
  endfunction

  always @(negedge clk) begin
    logic [1:0] exp_rdy, exp_rv;
    logic       exp_we;
    int         g, base;
    if (!shadow_ready) begin
      for (int i = 0; i < 512; i++)
        for (int b = 0; b < 4; b++) shadow[4*i + b] = init_word(i)[8*b +: 8];
      shadow_ready = 1;
    end
    acc[0] = 0;
    acc[1] = 0;
    if (mem_we) begin
      we_count++;
      last_wd = mem_wd;
    end
    if (!rst_n) begin
      check("rst_ready", {30'd0, req_ready}, 32'd0);
      check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      m_busy = 0;
      m_rr_last = 1;
    end else begin
      exp_rdy = 2'b00;
      if (!m_busy) exp_rdy = (req_valid == 2'b11) ? (m_rr_last ? 2'b01 : 2'b10) : req_valid;
      check("ready", {30'd0, req_ready}, {30'd0, exp_rdy});
      exp_rv = (m_busy && m_k == m_resp_k) ? 2'(1 << m_id) : 2'b00;
      exp_we = m_busy && (m_k == m_wr_k);
      check("rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_rv});
      check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      if (exp_rv != 2'b00) begin
        check("rsp_rdata", rsp_rdata, m_rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
        last_rdata[m_id] = rsp_rdata;
        last_err[m_id]   = rsp_err;
        rsp_cyc[m_id]    = cyc;
        rsp_cnt[m_id]++;
      end
      if (m_busy && (m_k == 1 || exp_we)) check("mem_addr", mem_addr, m_addr & ~32'd3);
      if (exp_we) check("mem_wd", mem_wd, m_wd);
      if (m_busy) begin
        if (exp_we) begin
          base = int'(m_addr) & ~3;
          for (int i = 0; i < 4; i++) shadow[base + i] = m_wd[8*i +: 8];
        end
        if (m_k == m_resp_k) m_busy = 0;
        else m_k++;
      end else if (exp_rdy != 2'b00) begin
        g = exp_rdy[1] ? 1 : 0;
        m_id    = g;
        m_addr  = req_addr[32*g +: 32];
        m_wdata = req_wdata[32*g +: 32];
        m_nb    = (req_size[2*g +: 2] == 2'd0) ? 1 : (req_size[2*g +: 2] == 2'd1) ? 2 : 4;
        m_err   = (req_size[2*g +: 2] == 2'd3) || (int'(m_addr % 32'(m_nb)) != 0) ||
                  ((m_addr & ~32'd3) > 32'(MEM_BYTES - 4));
        m_rdata = 32'd0;
        m_wd    = 32'd0;
        m_wr_k  = 0;
        m_resp_k = 2;
        if (!m_err) begin
          if (!req_we[g]) m_rdata = load_val(m_addr, m_nb, req_uns[g]);
          else if (m_nb == 4) begin
            m_wd = m_wdata;
            m_wr_k = 1;
          end else begin
            m_wd = merge_val(m_addr, m_nb, m_wdata);
            m_wr_k = 2;
            m_resp_k = 3;
          end
        end
        m_busy = 1;
        m_k = 1;
        m_rr_last = g[0];
        acc[g] = 1;
        xfer_cyc[g] = cyc;
        grant_log.push_back(g);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int p, input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_valid[p] = 1'b1;
    req_we[p] = we;
    req_size[2*p +: 2] = sz;
    req_uns[p] = uns;
    req_addr[32*p +: 32] = addr;
    req_wdata[32*p +: 32] = wd;
  endtask

  task automatic wait_acc(input int p);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!acc[p] && n < 100);
    if (!acc[p]) check("accept_timeout", 32'd0, 32'd1);
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (m_busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (m_busy) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input int p, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    set_req(p, we, sz, uns, addr, wd);
    wait_acc(p);
    wait_done();
  endtask

  task automatic rand_req(input int p);
    logic [2:0] s;
    logic [1:0] sz;
    logic [31:0] a;
    s  = 3'($urandom_range(0, 7));
    sz = (s == 3'd7) ? 2'd3 : 2'(s % 3'd3);
    a  = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(2040, 2103)) : 32'($urandom_range(0, 2047));
    set_req(p, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  initial begin
    int wc, rc0, rc1, gstart, cnt0, cnt1, n;
    logic [31:0] w0;
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_size = '0; req_uns = '0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: word store then word load
    wc = we_count;
    do_req(0, 1, 2'b10, 0, 32'h8, 32'hDACBF567);
    check("t1_sw_we_once", 32'(we_count - wc), 32'd1);
    do_req(0, 0, 2'b10, 0, 32'h8, 32'h0);
    check("t1_lw_data", last_rdata[0], 32'hDACBF567);
    check("t1_lw_err", {31'd0, last_err[0]}, 32'd0);
    check("t1_lw_latency", 32'(rsp_cyc[0] - xfer_cyc[0]), 32'd2);

    // 2: byte store by read-modify-write, then signed/unsigned byte loads
    do_req(0, 1, 2'b00, 0, 32'h9, 32'h000000AA);
    check("t2_sb_wd", last_wd, 32'hDACBAA67);
    check("t2_sb_latency", 32'(rsp_cyc[0] - xfer_cyc[0]), 32'd3);
    do_req(0, 0, 2'b00, 0, 32'h9, 32'h0);
    check("t2_lb", last_rdata[0], 32'hFFFFFFAA);
    do_req(0, 0, 2'b00, 1, 32'h9, 32'h0);
    check("t2_lbu", last_rdata[0], 32'h000000AA);

    // 4: error cases never write
    wc = we_count;
    do_req(0, 0, 2'b01, 0, 32'h3, 32'h0);
    check("t4_lh_mis_err", {31'd0, last_err[0]}, 32'd1);
    check("t4_err_latency", 32'(rsp_cyc[0] - xfer_cyc[0]), 32'd2);
    do_req(0, 1, 2'b10, 0, 32'h6, 32'h11223344);
    check("t4_sw_mis_err", {31'd0, last_err[0]}, 32'd1);
    do_req(0, 1, 2'b11, 0, 32'h0, 32'h55667788);
    check("t4_rsv_err", {31'd0, last_err[0]}, 32'd1);
    do_req(0, 0, 2'b10, 0, 32'h800, 32'h0);
    check("t4_oor_err", {31'd0, last_err[0]}, 32'd1);
    check("t4_oor_rdata", last_rdata[0], 32'd0);
    check("t4_no_write", 32'(we_count - wc), 32'd0);
    check("t4_mem_kept", mem[2], 32'hDACBAA67);

    // 5: reset during the write cycle of a halfword store
    w0 = mem[0];
    wc = we_count;
    rc0 = rsp_cnt[0];
    set_req(0, 1, 2'b01, 0, 32'h2, 32'h0000BEEF);
    wait_acc(0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t5_no_write", 32'(we_count - wc), 32'd0);
    check("t5_no_rsp", 32'(rsp_cnt[0] - rc0), 32'd0);
    check("t5_mem_kept", mem[0], w0);

    // 3: both ports continuously requesting alternate, starting with port 0
    gstart = grant_log.size();
    rc0 = rsp_cnt[0];
    rc1 = rsp_cnt[1];
    cnt0 = 0;
    cnt1 = 0;
    set_req(0, 0, 2'b10, 0, 32'h10, 32'h0);
    set_req(1, 0, 2'b10, 0, 32'h20, 32'h0);
    n = 0;
    while ((cnt0 < 4 || cnt1 < 4) && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (acc[0]) begin
        cnt0++;
        if (cnt0 < 4) set_req(0, 0, 2'b10, 0, 32'(16 + 4*cnt0), 32'h0);
        else req_valid[0] = 1'b0;
      end
      if (acc[1]) begin
        cnt1++;
        if (cnt1 < 4) set_req(1, 0, 2'b10, 0, 32'(32 + 4*cnt1), 32'h0);
        else req_valid[1] = 1'b0;
      end
    end
    wait_done();
    check("t3_grant_count", 32'(grant_log.size() - gstart), 32'd8);
    for (int i = 0; i < 8; i++)
      if (gstart + i < grant_log.size())
        check("t3_grant_order", 32'(grant_log[gstart + i]), 32'(i % 2));
    check("t3_rsp_p0", 32'(rsp_cnt[0] - rc0), 32'd4);
    check("t3_rsp_p1", 32'(rsp_cnt[1] - rc1), 32'd4);

    // 6: port 1 arrives while port 0 is busy
    set_req(0, 0, 2'b10, 0, 32'h8, 32'h0);
    wait_acc(0);
    set_req(1, 0, 2'b10, 0, 32'h8, 32'h0);
    wait_acc(1);
    check("t6_p1_accept_gap", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd3);
    wait_done();
    check("t6_p1_data", last_rdata[1], 32'hDACBAA67);
    check("t6_p0_data", last_rdata[0], 32'hDACBAA67);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) req_valid[p] = 1'b0;
        if (!req_valid[p] && $urandom_range(0, 2) == 0) rand_req(p);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = 2'b00;
    repeat (6) @(posedge clk);
    #1;
    n = 0;
    for (int i = 0; i < 512; i++)
      if (mem[i] !== {shadow[4*i+3], shadow[4*i+2], shadow[4*i+1], shadow[4*i]}) n++;
    check("final_mem_words_differing", 32'(n), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
